pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_frame_timer.sv | 36 +++
 rtl/pong_match_ctrl.sv | 157 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared state codes, direction-bit meanings and default geometry for the pong match controller.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // dir[DIR_RIGHT] = 1 means moving right, dir[DIR_UP] = 1 means moving up.
    localparam int         DIR_RIGHT = 1;
    localparam int         DIR_UP    = 0;
    localparam logic [1:0] DIR_RESET = 2'b10;

    localparam int DEF_ACTIVE_H = 640;
    localparam int DEF_ACTIVE_V = 480;
    localparam int DEF_PADDLE_W = 20;
    localparam int DEF_PADDLE_H = 80;
    localparam int DEF_BALL_W   = 20;
    localparam int DEF_BALL_H   = 20;
    localparam int DEF_P2_X     = 620;

    localparam logic [4:0] SCORE_SAT = 5'd31;

    function automatic logic [4:0] sat_inc(input logic [4:0] s);
        return (s == SCORE_SAT) ? s : s + 5'd1;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Counts frame ticks after a load; done is high on the tick that completes FRAMES ticks.
module pong_frame_timer #(
    parameter int FRAMES = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic frame_tick,
    output logic done
);

    localparam int            CW   = $clog2(FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAMES - 1);

    logic [CW-1:0] count_q, count_d;

    assign done = frame_tick && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (frame_tick) begin
            count_d = done ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve timing, paddle/wall/miss evaluation, scoring and win detection.
// Build option: PONG_WIN_BY_TWO_EN selects the win-by-two rule.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int MAX_SCORE    = 10,
    parameter int SERVE_FRAMES = 60,
    parameter int ACTIVE_H     = DEF_ACTIVE_H,
    parameter int ACTIVE_V     = DEF_ACTIVE_V,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int BALL_W       = DEF_BALL_W,
    parameter int BALL_H       = DEF_BALL_H,
    parameter int P2_X         = DEF_P2_X
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    output logic       serve,
    output logic [1:0] dir,
    output logic [4:0] score1,
    output logic [4:0] score2,
    output logic [2:0] state,
    output logic       game_over
);

    localparam logic [10:0] ACT_H = 11'(ACTIVE_H);
    localparam logic [10:0] ACT_V = 11'(ACTIVE_V);
    localparam logic [10:0] PAD_W = 11'(PADDLE_W);
    localparam logic [10:0] PAD_H = 11'(PADDLE_H);
    localparam logic [10:0] BAL_W = 11'(BALL_W);
    localparam logic [10:0] BAL_H = 11'(BALL_H);
    localparam logic [10:0] P2_XL = 11'(P2_X);
    localparam logic [5:0]  MAX_S = 6'(MAX_SCORE);

    state_e     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [4:0] score1_q, score1_d;
    logic [4:0] score2_q, score2_d;
    logic       p1_won_q, p1_won_d;

    logic timer_load, timer_tick, timer_done;

    pong_frame_timer #(.FRAMES(SERVE_FRAMES)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .frame_tick (timer_tick),
        .done       (timer_done)
    );

    // Edge and overlap terms, widened to 11 bits so sums never wrap.
    logic [10:0] bx, by, bx_r, by_b;
    logic        p1_hit, p2_hit, win;
    logic [5:0]  s1, s2;

    assign bx   = {1'b0, ball_x};
    assign by   = {1'b0, ball_y};
    assign bx_r = bx + BAL_W;
    assign by_b = by + BAL_H;

    assign p1_hit = (bx == PAD_W) && !dir_q[DIR_RIGHT] &&
                    (by <= {1'b0, p1_y} + PAD_H) && (by_b >= {1'b0, p1_y});
    assign p2_hit = (bx_r == P2_XL) && dir_q[DIR_RIGHT] &&
                    (by <= {1'b0, p2_y} + PAD_H) && (by_b >= {1'b0, p2_y});

    assign s1 = {1'b0, score1_q};
    assign s2 = {1'b0, score2_q};

`ifdef PONG_WIN_BY_TWO_EN
    assign win = ((s1 >= MAX_S) && (s1 >= s2 + 6'd2)) ||
                 ((s2 >= MAX_S) && (s2 >= s1 + 6'd2)) ||
                 (score1_q == SCORE_SAT) || (score2_q == SCORE_SAT);
`else
    assign win = (s1 == MAX_S) || (s2 == MAX_S);
`endif

    assign timer_tick = frame_tick && (state_q == ST_SERVE);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        p1_won_d   = p1_won_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score1_d   = '0;
                    score2_d   = '0;
                    timer_load = 1'b1;
                    state_d    = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (timer_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (bx_r >= ACT_H) begin
                        score1_d = sat_inc(score1_q);
                        p1_won_d = 1'b1;
                        state_d  = ST_POINT;
                    end else if (ball_x == 10'd0) begin
                        score2_d = sat_inc(score2_q);
                        p1_won_d = 1'b0;
                        state_d  = ST_POINT;
                    end else begin
                        if (p1_hit)      dir_d[DIR_RIGHT] = 1'b1;
                        else if (p2_hit) dir_d[DIR_RIGHT] = 1'b0;
                        if (ball_y == 10'd0 && dir_q[DIR_UP])     dir_d[DIR_UP] = 1'b0;
                        else if (by_b >= ACT_V && !dir_q[DIR_UP]) dir_d[DIR_UP] = 1'b1;
                    end
                end
            end
            ST_POINT: begin
                // The next serve heads toward the player who lost the point.
                timer_load       = 1'b1;
                dir_d[DIR_RIGHT] = p1_won_q;
                state_d          = win ? ST_OVER : ST_SERVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_RESET;
            score1_q <= '0;
            score2_q <= '0;
            p1_won_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            p1_won_q <= p1_won_d;
        end
    end

    assign serve     = (state_q == ST_SERVE) && timer_done;
    assign dir       = dir_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign state     = state_q;
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: a table of PLAY-tick vectors plus hand-written serve/score/reset sequences.
module tb_pong_match_ctrl;

    localparam int SERVE_FRAMES = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] ball_x = 10'd300;
    logic [9:0] ball_y = 10'd200;
    logic [9:0] p1_y = 10'd0;
    logic [9:0] p2_y = 10'd0;
    logic       serve;
    logic [1:0] dir;
    logic [4:0] score1, score2;
    logic [2:0] state;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    pong_match_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_tick (frame_tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .serve      (serve),
        .dir        (dir),
        .score1     (score1),
        .score2     (score2),
        .state      (state),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       ft;
        logic [9:0] bx, by, p1, p2;
        logic [1:0] exp_dir;
        logic [4:0] exp_s1, exp_s2;
        logic [2:0] exp_st;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic ft, input logic st);
        frame_tick = ft;
        start      = st;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
    endtask

    task automatic neutral_ball();
        ball_x = 10'd300;
        ball_y = 10'd200;
        p1_y   = 10'd0;
        p2_y   = 10'd0;
    endtask

    task automatic serve_wait();
        int pulses = 0;
        int at     = 0;
        neutral_ball();
        for (int i = 1; i <= SERVE_FRAMES; i++) begin
            frame_tick = 1'b1;
            #1;
            if (serve === 1'b1) begin
                pulses++;
                at = i;
            end
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
        end
        check("serve_pulses", pulses, 1);
        check("serve_at_tick", at, SERVE_FRAMES);
        check("serve_to_play", state, 3'd2);
        check("serve_low_after", serve, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 10'd300, 10'd200, 10'd0,   10'd0,   2'b10, 5'd0, 5'd0, 3'd2};
        vecs[1]  = '{1'b1, 10'd600, 10'd200, 10'd0,   10'd180, 2'b00, 5'd0, 5'd0, 3'd2};
        vecs[2]  = '{1'b1, 10'd600, 10'd200, 10'd0,   10'd180, 2'b00, 5'd0, 5'd0, 3'd2};
        vecs[3]  = '{1'b1, 10'd300, 10'd460, 10'd0,   10'd0,   2'b01, 5'd0, 5'd0, 3'd2};
        vecs[4]  = '{1'b1, 10'd20,  10'd100, 10'd50,  10'd0,   2'b11, 5'd0, 5'd0, 3'd2};
        vecs[5]  = '{1'b1, 10'd20,  10'd100, 10'd50,  10'd0,   2'b11, 5'd0, 5'd0, 3'd2};
        vecs[6]  = '{1'b1, 10'd600, 10'd0,   10'd0,   10'd0,   2'b00, 5'd0, 5'd0, 3'd2};
        vecs[7]  = '{1'b1, 10'd20,  10'd200, 10'd50,  10'd0,   2'b00, 5'd0, 5'd0, 3'd2};
        vecs[8]  = '{1'b1, 10'd20,  10'd200, 10'd220, 10'd0,   2'b10, 5'd0, 5'd0, 3'd2};
        vecs[9]  = '{1'b1, 10'd300, 10'd0,   10'd0,   10'd0,   2'b10, 5'd0, 5'd0, 3'd2};
        vecs[10] = '{1'b0, 10'd630, 10'd200, 10'd0,   10'd0,   2'b10, 5'd0, 5'd0, 3'd2};
        vecs[11] = '{1'b1, 10'd620, 10'd200, 10'd0,   10'd0,   2'b10, 5'd1, 5'd0, 3'd3};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 3'd0);
        check("rst_dir", dir, 2'b10);
        check("rst_s1", score1, 5'd0);
        check("rst_s2", score2, 5'd0);
        check("rst_serve", serve, 1'b0);
        check("rst_over", game_over, 1'b0);
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        check("idle_holds", state, 3'd0);

        // Start, then the serve delay.
        tick(1'b0, 1'b1);
        check("start_to_serve", state, 3'd1);
        serve_wait();

        // PLAY vectors: each tick's effect is visible one cycle later.
        foreach (vecs[i]) begin
            ball_x = vecs[i].bx;
            ball_y = vecs[i].by;
            p1_y   = vecs[i].p1;
            p2_y   = vecs[i].p2;
            tick(vecs[i].ft, 1'b0);
            check($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
            check($sformatf("vec%0d_s1", i), score1, vecs[i].exp_s1);
            check($sformatf("vec%0d_s2", i), score2, vecs[i].exp_s2);
            check($sformatf("vec%0d_state", i), state, vecs[i].exp_st);
        end

        // POINT ignores frame_tick; the next serve heads right toward P2.
        neutral_ball();
        tick(1'b1, 1'b0);
        check("point_to_serve", state, 3'd1);
        check("point_dir_right", dir, 2'b10);
        tick(1'b0, 1'b1);
        check("serve_ignores_start_st", state, 3'd1);
        check("serve_ignores_start_s1", score1, 5'd1);
        serve_wait();

        // Miss left: score2 increments, next serve heads left.
        ball_x = 10'd0;
        tick(1'b1, 1'b0);
        check("missl_s2", score2, 5'd1);
        check("missl_state", state, 3'd3);
        tick(1'b0, 1'b1);
        check("missl_serve", state, 3'd1);
        check("missl_dir", dir, 2'b00);
        serve_wait();

        // Run score1 up to the winning score.
        for (int k = 2; k <= 10; k++) begin
            ball_x = 10'd620;
            tick(1'b1, 1'b0);
            check($sformatf("run_s1_%0d", k), score1, k);
            check($sformatf("run_point_%0d", k), state, 3'd3);
            neutral_ball();
            tick(1'b0, 1'b0);
            if (k < 10) begin
                check($sformatf("run_serve_%0d", k), state, 3'd1);
                serve_wait();
            end else begin
                check("win_state", state, 3'd4);
                check("win_over", game_over, 1'b1);
            end
        end

        // OVER holds scores until start.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("over_hold_state", state, 3'd4);
        check("over_hold_s1", score1, 5'd10);
        check("over_hold_s2", score2, 5'd1);
        tick(1'b0, 1'b1);
        check("restart_state", state, 3'd1);
        check("restart_s1", score1, 5'd0);
        check("restart_s2", score2, 5'd0);
        check("restart_over", game_over, 1'b0);
        serve_wait();

        // Score a point, return to PLAY, bounce off the floor, then reset mid-rally.
        ball_x = 10'd620;
        tick(1'b1, 1'b0);
        check("pre_rst_s1", score1, 5'd1);
        tick(1'b0, 1'b0);
        serve_wait();
        ball_y = 10'd460;
        tick(1'b1, 1'b0);
        check("pre_rst_dir", dir, 2'b11);
        neutral_ball();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", state, 3'd0);
        check("async_rst_s1", score1, 5'd0);
        check("async_rst_dir", dir, 2'b10);
        check("async_rst_serve", serve, 1'b0);
        check("async_rst_over", game_over, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        check("post_rst_state", state, 3'd0);
        check("post_rst_s1", score1, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
